// File: rtl/or1200_monitor_pkg.sv
// Shared opcode constants and decode result type for the OR1200 instruction monitor.
package or1200_monitor_pkg;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned K_W    = 16;

  // Upper half of an l.nop K instruction word.
  localparam logic [K_W-1:0] OR1200_NOP_OPC = 16'h1500;

  // Default simulation-control K values.
  localparam logic [K_W-1:0] OR1200_NOP_EXIT   = 16'h0001;
  localparam logic [K_W-1:0] OR1200_NOP_REPORT = 16'h0002;
  localparam logic [K_W-1:0] OR1200_NOP_PUTC   = 16'h0004;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_EXIT   = 2'd1,
    KIND_REPORT = 2'd2,
    KIND_PUTC   = 2'd3
  } nop_kind_t;

endpackage

// File: rtl/or1200_insn_monitor_if.sv
// Write-back stage view of the CPU as seen by the instruction monitor.
interface or1200_insn_monitor_if;

  logic [31:0] wb_insn;
  logic        wb_valid;
  logic [31:0] gpr_r3;

  modport master (output wb_insn, output wb_valid, output gpr_r3);
  modport slave  (input  wb_insn, input  wb_valid, input  gpr_r3);

endinterface

// File: rtl/or1200_nop_decode.sv
// Combinational classifier for simulation-control l.nop K instructions.
module or1200_nop_decode
  import or1200_monitor_pkg::*;
#(
  parameter logic [15:0] NOP_EXIT   = OR1200_NOP_EXIT,
  parameter logic [15:0] NOP_REPORT = OR1200_NOP_REPORT,
  parameter logic [15:0] NOP_PUTC   = OR1200_NOP_PUTC
) (
  input  logic        wb_valid_i,
  input  logic [31:0] wb_insn_i,
  output nop_kind_t   nop_kind_c
);

  logic [K_W-1:0] k_c;
  assign k_c = wb_insn_i[K_W-1:0];

  // Only valid l.nop words with a known K produce an event; the bubble word has a different opcode half.
  always_comb begin
    nop_kind_c = KIND_NONE;
    if (wb_valid_i && (wb_insn_i[INSN_W-1:K_W] == OR1200_NOP_OPC)) begin
      if (k_c == NOP_EXIT) begin
        nop_kind_c = KIND_EXIT;
      end else if (k_c == NOP_REPORT) begin
        nop_kind_c = KIND_REPORT;
      end else if (k_c == NOP_PUTC) begin
        nop_kind_c = KIND_PUTC;
      end
    end
  end

endmodule

// File: rtl/or1200_insn_monitor.sv
// Retired-instruction counter and simulation-control nop event monitor for OR1200.
module or1200_insn_monitor
  import or1200_monitor_pkg::*;
#(
  parameter logic [15:0] NOP_EXIT   = OR1200_NOP_EXIT,
  parameter logic [15:0] NOP_REPORT = OR1200_NOP_REPORT,
  parameter logic [15:0] NOP_PUTC   = OR1200_NOP_PUTC,
  parameter int unsigned CNT_W      = 32,
  // Lets an enclosing bench keep running after the program exits.
  parameter bit          SIM_FINISH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  or1200_insn_monitor_if.slave wb,
  output logic [CNT_W-1:0] insn_count,
  output logic             exit_o,
  output logic [31:0]      exit_code,
  output logic             report_o,
  output logic [31:0]      report_data,
  output logic             putc_o,
  output logic [7:0]       putc_char,
  output logic             halted
);

  nop_kind_t        nop_kind_c;
  logic             retire_c;

  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             halted_q,      halted_d;
  logic             exit_q,        exit_d;
  logic             report_q,      report_d;
  logic             putc_q,        putc_d;
  logic [31:0]      exit_code_q,   exit_code_d;
  logic [31:0]      report_data_q, report_data_d;
  logic [7:0]       putc_char_q,   putc_char_d;

  or1200_nop_decode #(
    .NOP_EXIT   (NOP_EXIT),
    .NOP_REPORT (NOP_REPORT),
    .NOP_PUTC   (NOP_PUTC)
  ) u_nop_decode (
    .wb_valid_i (wb.wb_valid),
    .wb_insn_i  (wb.wb_insn),
    .nop_kind_c (nop_kind_c)
  );

  // Once halted, the CPU side is ignored entirely until reset.
  assign retire_c = wb.wb_valid & ~halted_q;

  // Next-state: count retirements, capture r3 and fire one-cycle strobes for control nops.
  always_comb begin
    cnt_d         = cnt_q;
    halted_d      = halted_q;
    exit_d        = 1'b0;
    report_d      = 1'b0;
    putc_d        = 1'b0;
    exit_code_d   = exit_code_q;
    report_data_d = report_data_q;
    putc_char_d   = putc_char_q;
    if (retire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (nop_kind_c)
        KIND_EXIT: begin
          exit_d      = 1'b1;
          exit_code_d = wb.gpr_r3;
          halted_d    = 1'b1;
        end
        KIND_REPORT: begin
          report_d      = 1'b1;
          report_data_d = wb.gpr_r3;
        end
        KIND_PUTC: begin
          putc_d      = 1'b1;
          putc_char_d = wb.gpr_r3[7:0];
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      halted_q      <= 1'b0;
      exit_q        <= 1'b0;
      report_q      <= 1'b0;
      putc_q        <= 1'b0;
      exit_code_q   <= '0;
      report_data_q <= '0;
      putc_char_q   <= '0;
    end else begin
      cnt_q         <= cnt_d;
      halted_q      <= halted_d;
      exit_q        <= exit_d;
      report_q      <= report_d;
      putc_q        <= putc_d;
      exit_code_q   <= exit_code_d;
      report_data_q <= report_data_d;
      putc_char_q   <= putc_char_d;
    end
  end

  assign insn_count  = cnt_q;
  assign halted      = halted_q;
  assign exit_o      = exit_q;
  assign exit_code   = exit_code_q;
  assign report_o    = report_q;
  assign report_data = report_data_q;
  assign putc_o      = putc_q;
  assign putc_char   = putc_char_q;

`ifndef SYNTHESIS
  // Console side effects of the control nops, one edge after each strobe is raised.
  always @(posedge clk) begin
    if (rst_n) begin
      if (report_q) begin
        $display("report (0x%08h)", report_data_q);
      end
      if (putc_q) begin
        $write("%c", putc_char_q);
      end
      if (exit_q) begin
        $display("exit(0x%08h) after %0d instructions", exit_code_q, cnt_q);
        if (SIM_FINISH) begin
          $finish;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_or1200_insn_monitor.sv
// Directed bench for the OR1200 instruction monitor with a transaction-level reference model.
module tb_or1200_insn_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  or1200_insn_monitor_if wb_if ();

  logic [31:0] insn_count;
  logic        exit_o, report_o, putc_o, halted;
  logic [31:0] exit_code, report_data;
  logic [7:0]  putc_char;

  logic [3:0]  d4_count;
  logic        d4_exit_o, d4_report_o, d4_putc_o, d4_halted;
  logic [31:0] d4_exit_code, d4_report_data;
  logic [7:0]  d4_putc_char;

  or1200_insn_monitor #(.CNT_W(32), .SIM_FINISH(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb_if),
    .insn_count  (insn_count),
    .exit_o      (exit_o),
    .exit_code   (exit_code),
    .report_o    (report_o),
    .report_data (report_data),
    .putc_o      (putc_o),
    .putc_char   (putc_char),
    .halted      (halted)
  );

  or1200_insn_monitor #(.CNT_W(4), .SIM_FINISH(1'b0)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb_if),
    .insn_count  (d4_count),
    .exit_o      (d4_exit_o),
    .exit_code   (d4_exit_code),
    .report_o    (d4_report_o),
    .report_data (d4_report_data),
    .putc_o      (d4_putc_o),
    .putc_char   (d4_putc_char),
    .halted      (d4_halted)
  );

  // Reference model: expected outputs after the next rising edge.
  logic [31:0] m_cnt;
  logic        m_halted, m_exit, m_report, m_putc;
  logic [31:0] m_exit_code, m_report_data;
  logic [7:0]  m_putc_char;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_halted = 0; m_exit = 0; m_report = 0; m_putc = 0;
    m_exit_code = '0; m_report_data = '0; m_putc_char = '0;
  endtask

  // Present one write-back slot for one cycle and predict its effect.
  task automatic step(input logic v, input logic [31:0] insn, input logic [31:0] r3);
    @(negedge clk);
    wb_if.wb_valid = v;
    wb_if.wb_insn  = insn;
    wb_if.gpr_r3   = r3;
    m_exit = 0; m_report = 0; m_putc = 0;
    if (v && !m_halted) begin
      m_cnt = m_cnt + 1;
      if (insn[31:16] == 16'h1500) begin
        if (insn[15:0] == 16'h0001) begin
          m_exit = 1; m_exit_code = r3; m_halted = 1;
        end else if (insn[15:0] == 16'h0002) begin
          m_report = 1; m_report_data = r3;
        end else if (insn[15:0] == 16'h0004) begin
          m_putc = 1; m_putc_char = r3[7:0];
        end
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0;
    wb_if.wb_valid = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("insn_count",  insn_count,          m_cnt);
      chk("cnt_w4",      32'(d4_count),       {28'd0, m_cnt[3:0]});
      chk("halted",      32'(halted),         32'(m_halted));
      chk("halted_w4",   32'(d4_halted),      32'(m_halted));
      chk("exit_o",      32'(exit_o),         32'(m_exit));
      chk("exit_code",   exit_code,           m_exit_code);
      chk("report_o",    32'(report_o),       32'(m_report));
      chk("report_data", report_data,         m_report_data);
      chk("putc_o",      32'(putc_o),         32'(m_putc));
      chk("putc_char",   32'(putc_char),      32'(m_putc_char));
      chk("strobes_w4",  32'({d4_exit_o, d4_report_o, d4_putc_o}), 32'({m_exit, m_report, m_putc}));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    wb_if.wb_valid = 0;
    wb_if.wb_insn  = '0;
    wb_if.gpr_r3   = '0;
    model_reset();
    reset_dut();
    settle();
    chk("rst_count", insn_count, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Ten ordinary retirements.
    for (int i = 0; i < 10; i++) step(1'b1, 32'hE000_0004, 32'(i));
    settle();
    chk("lit_count10", insn_count, 32'd10);
    chk("lit_no_strobes", 32'({exit_o, report_o, putc_o}), 32'd0);

    // Bubbles with valid low interleaved with three valid instructions.
    reset_dut();
    step(1'b0, 32'h1441_0000, 32'h0);
    step(1'b1, 32'hE000_0004, 32'h0);
    step(1'b0, 32'h1441_0000, 32'h0);
    step(1'b1, 32'hA820_0010, 32'h0);
    step(1'b0, 32'h1441_0000, 32'h0);
    step(1'b1, 32'hE000_0004, 32'h0);
    step(1'b0, 32'h1441_0000, 32'h0);
    settle();
    chk("lit_count3", insn_count, 32'd3);

    // Unknown K is an ordinary instruction.
    step(1'b1, 32'h1500_0007, 32'h0000_0055);
    settle();
    chk("lit_count_k7", insn_count, 32'd4);
    chk("lit_k7_no_strobes", 32'({exit_o, report_o, putc_o}), 32'd0);

    // putc followed immediately by report.
    step(1'b1, 32'h1500_0004, 32'h0000_0041);
    settle();
    chk("lit_putc_o", 32'(putc_o), 32'd1);
    chk("lit_putc_char", 32'(putc_char), 32'h41);
    step(1'b1, 32'h1500_0002, 32'hDEAD_BEEF);
    settle();
    chk("lit_report_o", 32'(report_o), 32'd1);
    chk("lit_report_data", report_data, 32'hDEAD_BEEF);
    chk("lit_putc_dropped", 32'(putc_o), 32'd0);
    chk("lit_count6", insn_count, 32'd6);

    // Exit, then activity while halted is ignored.
    step(1'b1, 32'h1500_0001, 32'h0000_0000);
    settle();
    chk("lit_exit_o", 32'(exit_o), 32'd1);
    chk("lit_exit_code", exit_code, 32'h0);
    chk("lit_halted", 32'(halted), 32'd1);
    chk("lit_count7", insn_count, 32'd7);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h1500_0002, 32'h1234_5678);
    settle();
    chk("lit_frozen_count", insn_count, 32'd7);
    chk("lit_frozen_report", report_data, 32'hDEAD_BEEF);
    chk("lit_frozen_strobe", 32'({exit_o, report_o, putc_o}), 32'd0);

    // Asynchronous reset between edges while halted.
    #1;
    rst_n = 0;
    wb_if.wb_valid = 0;
    model_reset();
    #1;
    chk("async_count", insn_count, 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_data", report_data | exit_code | 32'(putc_char), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Counter wrap in the 4-bit instance.
    for (int i = 0; i < 17; i++) step(1'b1, 32'hE000_0004, 32'h0);
    settle();
    chk("lit_wrap_w4", 32'(d4_count), 32'd1);
    chk("lit_count17", insn_count, 32'd17);

    // Exit with a non-zero code; a second exit while halted has no effect.
    step(1'b1, 32'h1500_0001, 32'h0000_00AB);
    settle();
    chk("lit_exit_code_ab", exit_code, 32'h0000_00AB);
    chk("lit_count18", insn_count, 32'd18);
    step(1'b1, 32'h1500_0001, 32'h0000_00FF);
    settle();
    chk("lit_exit_hold", exit_code, 32'h0000_00AB);
    chk("lit_exit_no_pulse", 32'(exit_o), 32'd0);

    step(1'b0, 32'h0, 32'h0);
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
